// File: rtl/intr_arbiter.sv
// ============================================================================
// intr_arbiter : edge-latching interrupt arbiter with IOBUS register window
// Rev 1.0
// ============================================================================
`default_nettype none

module intr_arbiter #(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_SRC-1:0] IRQ_IN,
   input  logic               INT_TAKEN,
   input  logic [31:0]        IOBUS_ADDR,
   input  logic [31:0]        IOBUS_OUT,
   input  logic               IOBUS_WR,
   output logic [31:0]        IO_RD_DATA,
   output logic               INTR,
   output logic [4:0]         ACTIVE_ID
);

   localparam logic [1:0] OFF_ENABLE  = 2'd0;
   localparam logic [1:0] OFF_PENDING = 2'd1;
   localparam logic [1:0] OFF_ACTIVE  = 2'd2;
   localparam logic [1:0] OFF_EOI     = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] irq_prev_q;
   logic [4:0]         active_id_q, active_id_d;
   logic               intr_q, intr_d;

   logic               w_in_window;
   logic [1:0]         w_offset;
   logic               w_wr_enable, w_wr_pending, w_wr_eoi;
   logic [NUM_SRC-1:0] w_wdata;
   logic [NUM_SRC-1:0] w_rise;
   logic [NUM_SRC-1:0] w_w1c_mask;
   logic [NUM_SRC-1:0] w_act_mask;
   logic [NUM_SRC-1:0] w_taken_clr;
   logic [NUM_SRC-1:0] w_eligible;
   logic [4:0]         w_winner;
   logic               w_active_ok;

   // Register window: 16 bytes, word-aligned accesses only.
   assign w_in_window  = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]) && (IOBUS_ADDR[1:0] == 2'b00);
   assign w_offset     = IOBUS_ADDR[3:2];
   assign w_wr_enable  = IOBUS_WR && w_in_window && (w_offset == OFF_ENABLE);
   assign w_wr_pending = IOBUS_WR && w_in_window && (w_offset == OFF_PENDING);
   assign w_wr_eoi     = IOBUS_WR && w_in_window && (w_offset == OFF_EOI);
   assign w_wdata      = NUM_SRC'(IOBUS_OUT);

   assign w_rise       = IRQ_IN & ~irq_prev_q;
   assign w_w1c_mask   = w_wr_pending ? w_wdata : '0;
   assign w_act_mask   = NUM_SRC'(1) << active_id_q;
   assign w_taken_clr  = ((state_q == S_REQ) && INT_TAKEN) ? w_act_mask : '0;

   // A fresh edge overrides any clear landing on the same bit in the same cycle.
   assign pending_d    = (pending_q & ~w_w1c_mask & ~w_taken_clr) | w_rise;
   assign enable_d     = w_wr_enable ? w_wdata : enable_q;

   assign w_eligible   = pending_q & enable_q;
   assign w_active_ok  = (|(pending_d & w_act_mask)) && (|(enable_d & w_act_mask));

   always_comb begin
      w_winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_winner = 5'(i);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      active_id_d = active_id_q;
      case (state_q)
         S_IDLE: begin
            if (|w_eligible) begin
               state_d     = S_REQ;
               active_id_d = w_winner;
            end
         end
         S_REQ: begin
            if (INT_TAKEN) begin
               state_d = S_SERVICE;
            end else if (!w_active_ok) begin
               state_d     = S_IDLE;
               active_id_d = '0;
            end
         end
         S_SERVICE: begin
            if (w_wr_eoi && (IOBUS_OUT[4:0] == active_id_q)) begin
               state_d     = S_IDLE;
               active_id_d = '0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            active_id_d = '0;
         end
      endcase
      intr_d = (state_d == S_REQ);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         enable_q    <= '0;
         pending_q   <= '0;
         irq_prev_q  <= '0;
         active_id_q <= '0;
         intr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         enable_q    <= enable_d;
         pending_q   <= pending_d;
         irq_prev_q  <= IRQ_IN;
         active_id_q <= active_id_d;
         intr_q      <= intr_d;
      end
   end

   always_comb begin
      IO_RD_DATA = '0;
      if (w_in_window) begin
         case (w_offset)
            OFF_ENABLE:  IO_RD_DATA = 32'(enable_q);
            OFF_PENDING: IO_RD_DATA = 32'(pending_q);
            OFF_ACTIVE:  IO_RD_DATA = {26'b0, (state_q != S_IDLE), active_id_q};
            default:     IO_RD_DATA = '0;
         endcase
      end
   end

   assign INTR      = intr_q;
   assign ACTIVE_ID = active_id_q;

endmodule

`default_nettype wire

// File: tb/tb_intr_arbiter.sv
// ============================================================================
// tb_intr_arbiter : directed stimulus with queued expectations and a monitor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_intr_arbiter;

   localparam int          NUM_SRC = 8;
   localparam logic [31:0] BASE    = 32'h1100_0100;
   localparam logic [31:0] A_EN    = BASE + 32'h0;
   localparam logic [31:0] A_PEND  = BASE + 32'h4;
   localparam logic [31:0] A_ACT   = BASE + 32'h8;
   localparam logic [31:0] A_EOI   = BASE + 32'hC;

   logic               CLK;
   logic               RST;
   logic [NUM_SRC-1:0] IRQ_IN;
   logic               INT_TAKEN;
   logic [31:0]        IOBUS_ADDR;
   logic [31:0]        IOBUS_OUT;
   logic               IOBUS_WR;
   logic [31:0]        IO_RD_DATA;
   logic               INTR;
   logic [4:0]         ACTIVE_ID;

   intr_arbiter #(.NUM_SRC(NUM_SRC), .BASE_ADDR(BASE)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IRQ_IN     (IRQ_IN),
      .INT_TAKEN  (INT_TAKEN),
      .IOBUS_ADDR (IOBUS_ADDR),
      .IOBUS_OUT  (IOBUS_OUT),
      .IOBUS_WR   (IOBUS_WR),
      .IO_RD_DATA (IO_RD_DATA),
      .INTR       (INTR),
      .ACTIVE_ID  (ACTIVE_ID)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic [31:0] rd;
      logic        intr;
      logic [4:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
      end
   end

   // Monitor: compares the queued expectation due in this cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
               failures++;
               $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (IO_RD_DATA !== e.rd || INTR !== e.intr || ACTIVE_ID !== e.id) begin
               failures++;
               $display("FAIL %s: got rd=%h intr=%b id=%0d, expected rd=%h intr=%b id=%0d",
                        e.name, IO_RD_DATA, INTR, ACTIVE_ID, e.rd, e.intr, e.id);
            end
         end
      end
   end

   task automatic cycle();
      @(posedge CLK);
      #1;
      IOBUS_WR  = 1'b0;
      INT_TAKEN = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      IOBUS_ADDR = addr;
      IOBUS_OUT  = data;
      IOBUS_WR   = 1'b1;
      cycle();
   endtask

   task automatic chk(input string name, input logic [31:0] addr, input logic [31:0] rd,
                      input logic intr, input logic [4:0] id);
      exp_t e;
      IOBUS_ADDR = addr;
      e.name = name;
      e.cyc  = cyc;
      e.rd   = rd;
      e.intr = intr;
      e.id   = id;
      exp_q.push_back(e);
   endtask

   initial begin
      RST = 1'b1; IRQ_IN = '0; INT_TAKEN = 1'b0;
      IOBUS_ADDR = '0; IOBUS_OUT = '0; IOBUS_WR = 1'b0;
      repeat (3) cycle();
      RST = 1'b0;
      chk("rst_enable", A_EN, 32'h0, 1'b0, 5'd0);   cycle();
      chk("rst_pending", A_PEND, 32'h0, 1'b0, 5'd0); cycle();
      chk("rst_active", A_ACT, 32'h0, 1'b0, 5'd0);   cycle();

      // Single source: edge -> pending, one edge later -> request.
      wr(A_EN, 32'hFFFF_FF05);
      chk("s1_enable_mask", A_EN, 32'h05, 1'b0, 5'd0); cycle();
      IRQ_IN = 8'h04; cycle();
      IRQ_IN = 8'h00;
      chk("s1_pending", A_PEND, 32'h04, 1'b0, 5'd0); cycle();
      chk("s1_request", A_ACT, 32'h22, 1'b1, 5'd2);
      INT_TAKEN = 1'b1; cycle();
      chk("s1_taken", A_PEND, 32'h0, 1'b0, 5'd2); cycle();
      wr(A_EOI, 32'd2);
      chk("s1_eoi", A_ACT, 32'h0, 1'b0, 5'd0); cycle();

      // Priority: 0 and 2 together, lowest wins; 2 follows after EOI.
      IRQ_IN = 8'h05; cycle();
      IRQ_IN = 8'h00; cycle();
      chk("s2_req0", A_ACT, 32'h20, 1'b1, 5'd0);
      INT_TAKEN = 1'b1; cycle();
      chk("s2_pend_after_take", A_PEND, 32'h04, 1'b0, 5'd0); cycle();
      wr(A_EOI, 32'd0);
      chk("s2_gap_low", A_ACT, 32'h0, 1'b0, 5'd0); cycle();
      chk("s2_req2", A_ACT, 32'h22, 1'b1, 5'd2);
      INT_TAKEN = 1'b1; cycle();
      wr(A_EOI, 32'd2);

      // Withdraw by disabling during request, then re-enable.
      wr(A_EN, 32'h08);
      IRQ_IN = 8'h08; cycle();
      IRQ_IN = 8'h00; cycle();
      chk("s3_req3", A_ACT, 32'h23, 1'b1, 5'd3); cycle();
      wr(A_EN, 32'h00);
      chk("s3_withdraw_pend", A_PEND, 32'h08, 1'b0, 5'd0); cycle();
      chk("s3_withdraw_act", A_ACT, 32'h0, 1'b0, 5'd0); cycle();
      wr(A_EN, 32'h08); cycle();
      chk("s3_reassert", A_ACT, 32'h23, 1'b1, 5'd3);
      INT_TAKEN = 1'b1; cycle();
      wr(A_EOI, 32'd3);

      // Mismatched EOI is ignored while in service.
      wr(A_EN, 32'h02);
      IRQ_IN = 8'h02; cycle();
      IRQ_IN = 8'h00; cycle();
      INT_TAKEN = 1'b1; cycle();
      wr(A_EOI, 32'd4);
      chk("s4_bad_eoi", A_ACT, 32'h21, 1'b0, 5'd1); cycle();
      wr(A_EOI, 32'd1);
      chk("s4_good_eoi", A_ACT, 32'h0, 1'b0, 5'd0); cycle();

      // Edge beats same-cycle W1C; held level does not re-pend.
      wr(A_EN, 32'h00);
      IRQ_IN = 8'h02; cycle();
      IRQ_IN = 8'h00;
      chk("s5_pre", A_PEND, 32'h02, 1'b0, 5'd0); cycle();
      IOBUS_ADDR = A_PEND; IOBUS_OUT = 32'h02; IOBUS_WR = 1'b1; IRQ_IN = 8'h02;
      cycle();
      chk("s5_set_wins", A_PEND, 32'h02, 1'b0, 5'd0); cycle();
      wr(A_EN, 32'h02); cycle();
      chk("s5_req1", A_ACT, 32'h21, 1'b1, 5'd1);
      INT_TAKEN = 1'b1; cycle();
      wr(A_EOI, 32'd1);
      repeat (20) cycle();
      chk("s5_level_once", A_PEND, 32'h0, 1'b0, 5'd0); cycle();
      IRQ_IN = 8'h12; cycle();
      IRQ_IN = 8'h02;
      chk("s5_masked_pend", A_PEND, 32'h10, 1'b0, 5'd0); cycle();
      wr(A_PEND, 32'h10);
      chk("s5_w1c", A_PEND, 32'h0, 1'b0, 5'd0); cycle();
      IRQ_IN = 8'h00;

      // Reset during request; out-of-window read.
      wr(A_EN, 32'h01);
      IRQ_IN = 8'h01; cycle();
      IRQ_IN = 8'h00; cycle();
      chk("s6_req0", A_ACT, 32'h20, 1'b1, 5'd0);
      RST = 1'b1; cycle();
      RST = 1'b0;
      chk("s6_rst_active", A_ACT, 32'h0, 1'b0, 5'd0); cycle();
      chk("s6_rst_enable", A_EN, 32'h0, 1'b0, 5'd0); cycle();
      chk("s6_rst_pending", A_PEND, 32'h0, 1'b0, 5'd0); cycle();
      chk("s6_outside", 32'h1100_0110, 32'h0, 1'b0, 5'd0); cycle();

      cycle();
      cycle();
      if (exp_q.size() != 0) begin
         checks   += exp_q.size();
         failures += exp_q.size();
         $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
